// File: rtl/mac_operand_feeder.sv
// Operand feeder for the matrix MAC. Loads (A,B) pairs into a ping-pong pair of
// N-entry banks and replays each full bank as a framed burst of N contiguous beats.
// Loading of the next vector overlaps streaming of the current one.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid_i/in_ready_o load handshake; in_a_i/in_b_i pair payload
//   out_en_i              downstream permits a burst to start (sampled in IDLE only)
//   out_sof_o/out_valid_o/out_last_o  burst framing; out_a_o/out_b_o streamed pair
//   busy_o                a bank holds data or a burst/gap is in progress
module mac_operand_feeder #(
  parameter int unsigned N     = 5,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             out_en_i,
  output logic             out_sof_o,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  output logic             busy_o
);

  localparam int unsigned   CW       = 8;
  localparam int unsigned   IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] BEATS    = CW'(N);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  state_e        state_q;
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q;
  logic [CW-1:0] gap_cnt_q;

  logic [WIDTH-1:0] mem_a [2][N];
  logic [WIDTH-1:0] mem_b [2][N];

  logic          load_c;
  logic          load_done_c;
  logic          start_c;
  logic          end_c;
  logic          idle_next_c;
  logic [IW-1:0] wr_idx_c;
  logic [IW-1:0] rd_idx_c;

  // Load bookkeeping and bank-full next state; a load completing one bank and a
  // burst releasing the other in the same cycle both land.
  always_comb begin
    load_c      = in_valid_i & in_ready_o;
    load_done_c = load_c & (wr_cnt_q == LAST_IDX);
    start_c     = (state_q == S_IDLE) & full_q[rd_bank_q] & out_en_i;
    // rd_cnt_q counts beats already issued, so reaching N means beat N-1 is on the bus
    end_c       = (state_q == S_STREAM) & (rd_cnt_q == BEATS);
    wr_idx_c    = IW'(wr_cnt_q);
    rd_idx_c    = IW'(rd_cnt_q);
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    idle_next_c = 1'b1;
    if (load_c) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end
    if (load_done_c) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_cnt_d          = '0;
    end
    if (end_c) begin
      full_d[rd_bank_q] = 1'b0;
    end
    unique case (state_q)
      S_IDLE:   idle_next_c = ~start_c;
      S_STREAM: idle_next_c = end_c & (GAP == 0);
      S_GAP:    idle_next_c = (gap_cnt_q == GAP_END);
      default:  idle_next_c = 1'b1;
    endcase
  end

  // Bank storage; stale contents are harmless because full_q gates every read.
  always_ff @(posedge clk) begin
    if (load_c) begin
      mem_a[wr_bank_q][wr_idx_c] <= in_a_i;
      mem_b[wr_bank_q][wr_idx_c] <= in_b_i;
    end
  end

  // Control FSM, bank pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      in_ready_o  <= 1'b1;
      busy_o      <= 1'b0;
      out_sof_o   <= 1'b0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_a_o     <= '0;
      out_b_o     <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      in_ready_o <= ~full_d[wr_bank_d];
      busy_o     <= (|full_d) | ~idle_next_c;
      out_sof_o  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_c) begin
            state_q     <= S_STREAM;
            rd_cnt_q    <= 8'd1;
            out_valid_o <= 1'b1;
            out_sof_o   <= 1'b1;
            out_last_o  <= (N == 1);
            out_a_o     <= mem_a[rd_bank_q][IW'(0)];
            out_b_o     <= mem_b[rd_bank_q][IW'(0)];
          end
        end
        S_STREAM: begin
          if (end_c) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_a_o     <= '0;
            out_b_o     <= '0;
            rd_bank_q   <= ~rd_bank_q;
            rd_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            state_q     <= (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            out_last_o <= (rd_cnt_q == LAST_IDX);
            out_a_o    <= mem_a[rd_bank_q][rd_idx_c];
            out_b_o    <= mem_b[rd_bank_q][rd_idx_c];
            rd_cnt_q   <= rd_cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          // Dwell GAP+1 cycles: GAP drain cycles after the MAC latches the last beat
          if (gap_cnt_q == GAP_END) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Testbench for mac_operand_feeder: dut0 (N=5, GAP=4) and dut1 (N=1, GAP=0).
// Expected bursts come from a queue of loaded pairs, framed every N pairs.
module tb_mac_operand_feeder;
  localparam int unsigned W  = 16;
  localparam int          N0 = 5;
  localparam int          G0 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0_n, v0, rdy0, en0, sof0, ov0, last0, busy0;
  logic [W-1:0] a0, b0, oa0, ob0;
  logic         rst1_n, v1, rdy1, en1, sof1, ov1, last1, busy1;
  logic [W-1:0] a1, b1, oa1, ob1;

  mac_operand_feeder #(.N(5), .WIDTH(W), .GAP(4)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .in_valid_i(v0), .in_ready_o(rdy0), .in_a_i(a0), .in_b_i(b0),
    .out_en_i(en0), .out_sof_o(sof0), .out_valid_o(ov0), .out_last_o(last0),
    .out_a_o(oa0), .out_b_o(ob0), .busy_o(busy0));

  mac_operand_feeder #(.N(1), .WIDTH(W), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid_i(v1), .in_ready_o(rdy1), .in_a_i(a1), .in_b_i(b1),
    .out_en_i(en1), .out_sof_o(sof1), .out_valid_o(ov1), .out_last_o(last1),
    .out_a_o(oa1), .out_b_o(ob1), .busy_o(busy1));

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sof;
    logic         last;
    logic [31:0]  cyc;
  } beat_t;

  pair_t       exp0[$], exp1[$];
  beat_t       obs0[$], obs1[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Record every streamed beat with its cycle number
  always @(negedge clk) begin
    if (ov0 === 1'b1) obs0.push_back(beat_t'{oa0, ob0, sof0, last0, cyc});
    if (ov1 === 1'b1) obs1.push_back(beat_t'{oa1, ob1, sof1, last1, cyc});
  end

  // Present one pair on dut d and hold it until accepted; called at a negedge
  task automatic push(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int waited);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    if (d == 0) begin v0 = 1'b1; a0 = a; b0 = b; end
    else        begin v1 = 1'b1; a1 = a; b1 = b; end
    while (!ok && t < 300) begin
      ok = (d == 0) ? (rdy0 === 1'b1) : (rdy1 === 1'b1);
      @(negedge clk);
      if (!ok) t++;
    end
    if (d == 0) v0 = 1'b0; else v1 = 1'b0;
    waited = t;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout dut%0d: accepted=0 required=1", d);
    end else if (d == 0) exp0.push_back(pair_t'{a, b});
    else exp1.push_back(pair_t'{a, b});
  endtask

  task automatic wait_obs(input int d, input int n);
    int t;
    t = 0;
    while (((d == 0) ? obs0.size() : obs1.size()) < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (((d == 0) ? obs0.size() : obs1.size()) < n) begin
      errors++;
      $display("FAIL beat_timeout dut%0d: beats=%0d required=%0d", d,
               (d == 0) ? obs0.size() : obs1.size(), n);
    end
  endtask

  task automatic test_reset();
    logic  g[9];
    logic  e[9];
    string nm[9];
    rst0_n = 1'b0; rst1_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    g  = '{rdy0, ov0, sof0, last0, busy0, rdy1, ov1, sof1, last1};
    e  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    nm = '{"in_ready0", "out_valid0", "out_sof0", "out_last0", "busy0",
           "in_ready1", "out_valid1", "out_sof1", "out_last1"};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (g[i] !== e[i]) begin
        errors++;
        $display("FAIL reset_%s: got %b want %b", nm[i], g[i], e[i]);
      end
    end
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_vector();
    int w;
    int sum;
    exp0.delete(); obs0.delete();
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 16'(2 * i + 1), 16'(2 * i + 2), w);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || rdy0 !== 1'b1 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got busy=%b ready=%b valid=%b want 1 1 0", busy0, rdy0, ov0);
    end
    en0 = 1'b1;
    wait_obs(0, 5);
    sum = 0;
    for (int k = 0; k < 5 && k < obs0.size(); k++) begin
      sum += int'(obs0[k].a) * int'(obs0[k].b);
      checks++;
      if (obs0[k].a !== exp0[k].a || obs0[k].b !== exp0[k].b || obs0[k].sof !== (k == 0) ||
          obs0[k].last !== (k == 4) || obs0[k].cyc !== obs0[0].cyc + 32'(k)) begin
        errors++;
        $display("FAIL single_beat%0d: got a=%0d b=%0d sof=%b last=%b cyc+%0d want a=%0d b=%0d sof=%b last=%b cyc+%0d",
                 k, obs0[k].a, obs0[k].b, obs0[k].sof, obs0[k].last, obs0[k].cyc - obs0[0].cyc,
                 exp0[k].a, exp0[k].b, k == 0, k == 4, k);
      end
    end
    checks++;
    if (sum != 190) begin
      errors++;
      $display("FAIL single_mac_sum: got %0d want 190", sum);
    end
    repeat (10) @(negedge clk);
    en0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || ov0 !== 1'b0 || oa0 !== '0 || ob0 !== '0 || obs0.size() != 5) begin
      errors++;
      $display("FAIL single_after: got busy=%b valid=%b a=%0d b=%0d beats=%0d want 0 0 0 0 5",
               busy0, ov0, oa0, ob0, obs0.size());
    end
  endtask

  task automatic test_overlap();
    int w;
    int stall;
    exp0.delete(); obs0.delete();
    en0 = 1'b1;
    stall = 0;
    for (int i = 0; i < 10; i++) begin
      push(0, 16'($urandom), 16'($urandom), w);
      stall += w;
    end
    checks++;
    if (stall != 0) begin
      errors++;
      $display("FAIL overlap_stall: got %0d stall cycles want 0", stall);
    end
    wait_obs(0, 10);
    for (int k = 0; k < 10 && k < obs0.size(); k++) begin
      checks++;
      if (obs0[k].a !== exp0[k].a || obs0[k].b !== exp0[k].b ||
          obs0[k].sof !== (k % N0 == 0) || obs0[k].last !== (k % N0 == N0 - 1)) begin
        errors++;
        $display("FAIL overlap_beat%0d: got a=%h b=%h sof=%b last=%b want a=%h b=%h sof=%b last=%b",
                 k, obs0[k].a, obs0[k].b, obs0[k].sof, obs0[k].last,
                 exp0[k].a, exp0[k].b, k % N0 == 0, k % N0 == N0 - 1);
      end
    end
    if (obs0.size() >= 10) begin
      checks++;
      if (obs0[5].cyc - obs0[0].cyc !== 32'(N0 + G0 + 2)) begin
        errors++;
        $display("FAIL overlap_sof_spacing: got %0d want %0d", obs0[5].cyc - obs0[0].cyc, N0 + G0 + 2);
      end
    end
    repeat (12) @(negedge clk);
    en0 = 1'b0;
  endtask

  task automatic test_backpressure();
    int w;
    int stall;
    int nsof;
    exp0.delete(); obs0.delete();
    en0 = 1'b0;
    stall = 0;
    for (int i = 0; i < 10; i++) begin
      push(0, 16'($urandom), 16'($urandom), w);
      stall += w;
    end
    checks++;
    if (stall != 0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got stall=%0d ready=%b want 0 0", stall, rdy0);
    end
    en0 = 1'b1;
    push(0, 16'($urandom), 16'($urandom), w);
    checks++;
    if (w != N0 + 1) begin
      errors++;
      $display("FAIL bp_release: got wait %0d want %0d", w, N0 + 1);
    end
    for (int i = 0; i < 4; i++) push(0, 16'($urandom), 16'($urandom), w);
    wait_obs(0, 15);
    nsof = 0;
    for (int k = 0; k < 15 && k < obs0.size(); k++) begin
      nsof += int'(obs0[k].sof);
      checks++;
      if (obs0[k].a !== exp0[k].a || obs0[k].b !== exp0[k].b ||
          obs0[k].sof !== (k % N0 == 0) || obs0[k].last !== (k % N0 == N0 - 1)) begin
        errors++;
        $display("FAIL bp_beat%0d: got a=%h b=%h sof=%b last=%b want a=%h b=%h sof=%b last=%b",
                 k, obs0[k].a, obs0[k].b, obs0[k].sof, obs0[k].last,
                 exp0[k].a, exp0[k].b, k % N0 == 0, k % N0 == N0 - 1);
      end
    end
    checks++;
    if (nsof != 3) begin
      errors++;
      $display("FAIL bp_sof_count: got %0d want 3", nsof);
    end
    repeat (12) @(negedge clk);
    en0 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int w;
    int t;
    bit seen_last;
    exp0.delete(); obs0.delete();
    en0 = 1'b1;
    for (int i = 0; i < 5; i++) push(0, 16'($urandom), 16'($urandom), w);
    t = 0;
    while (sof0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    checks++;
    if (ov0 !== 1'b1 || oa0 !== exp0[2].a) begin
      errors++;
      $display("FAIL rst_burst_beat2: got valid=%b a=%h want 1 %h", ov0, oa0, exp0[2].a);
    end
    rst0_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || sof0 !== 1'b0 || last0 !== 1'b0 || oa0 !== '0 || ob0 !== '0 ||
        busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_burst_outputs: got valid=%b sof=%b last=%b a=%h b=%h busy=%b ready=%b want 0 0 0 0 0 0 1",
               ov0, sof0, last0, oa0, ob0, busy0, rdy0);
    end
    rst0_n = 1'b1;
    repeat (30) @(negedge clk);
    seen_last = 1'b0;
    foreach (obs0[k]) if (obs0[k].last) seen_last = 1'b1;
    checks++;
    if (obs0.size() != 3 || seen_last) begin
      errors++;
      $display("FAIL rst_burst_drop: got beats=%0d last_seen=%b want 3 0", obs0.size(), seen_last);
    end
    // Partial load discarded by reset: the next vector must start at pair 0
    en0 = 1'b0;
    push(0, 16'hdead, 16'hbeef, w);
    push(0, 16'hcafe, 16'hf00d, w);
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    exp0.delete(); obs0.delete();
    for (int i = 0; i < 5; i++) push(0, 16'($urandom), 16'($urandom), w);
    en0 = 1'b1;
    wait_obs(0, 5);
    for (int k = 0; k < 5 && k < obs0.size(); k++) begin
      checks++;
      if (obs0[k].a !== exp0[k].a || obs0[k].b !== exp0[k].b ||
          obs0[k].sof !== (k == 0) || obs0[k].last !== (k == 4)) begin
        errors++;
        $display("FAIL rst_load_beat%0d: got a=%h b=%h sof=%b last=%b want a=%h b=%h sof=%b last=%b",
                 k, obs0[k].a, obs0[k].b, obs0[k].sof, obs0[k].last,
                 exp0[k].a, exp0[k].b, k == 0, k == 4);
      end
    end
    repeat (12) @(negedge clk);
    en0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w;
    exp1.delete(); obs1.delete();
    en1 = 1'b0;
    push(1, 16'hffff, 16'hffff, w);
    push(1, 16'($urandom), 16'($urandom), w);
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) push(1, 16'($urandom), 16'($urandom), w);
    wait_obs(1, 6);
    for (int k = 0; k < 6 && k < obs1.size(); k++) begin
      checks++;
      if (obs1[k].a !== exp1[k].a || obs1[k].b !== exp1[k].b || obs1[k].sof !== 1'b1 ||
          obs1[k].last !== 1'b1 || (k > 0 && obs1[k].cyc - obs1[k-1].cyc !== 32'd2)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got a=%h b=%h sof=%b last=%b spacing=%0d want a=%h b=%h sof=1 last=1 spacing=2",
                 k, obs1[k].a, obs1[k].b, obs1[k].sof, obs1[k].last,
                 (k > 0) ? obs1[k].cyc - obs1[k-1].cyc : 32'd2, exp1[k].a, exp1[k].b);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (obs1.size() != 6 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: got beats=%0d busy=%b want 6 0", obs1.size(), busy1);
    end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_overlap();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
